// File: rtl/reg_file_if.sv
// Port bundle between the DOF/write-back stages and the register file.
// Reads are combinational; writes and reservations are accepted unconditionally at the clock edge.
interface reg_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] AA;
    logic [ADDR_W-1:0] BA;
    logic [WIDTH-1:0]  A_DATA;
    logic [WIDTH-1:0]  B_DATA;
    logic              RW;
    logic [ADDR_W-1:0] DA;
    logic [WIDTH-1:0]  D_DATA;
    logic              RES_EN;
    logic [ADDR_W-1:0] RES_DA;
    logic              A_BUSY;
    logic              B_BUSY;

    modport master (
        output AA, BA, RW, DA, D_DATA, RES_EN, RES_DA,
        input  A_DATA, B_DATA, A_BUSY, B_BUSY
    );

    modport slave (
        input  AA, BA, RW, DA, D_DATA, RES_EN, RES_DA,
        output A_DATA, B_DATA, A_BUSY, B_BUSY
    );
endinterface

// File: rtl/reg_file.sv
// Two-read/one-write register file with R0 hardwired to zero, write-through bypass
// and a per-register pending-write scoreboard for RAW hazard detection.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic      CLOCK,
    input  logic      RESET,
    reg_file_if.slave rf
);
    localparam int NREG = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;

    logic wr_en;
    logic res_en;
    logic hit_a;
    logic hit_b;

    assign wr_en  = rf.RW && (rf.DA != '0);
    assign res_en = rf.RES_EN && (rf.RES_DA != '0);

    // Entry 0 is never written, so regs_q[0] and busy_q[0] stay zero after reset.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en) begin
            regs_d[rf.DA] = rf.D_DATA;
            busy_d[rf.DA] = 1'b0;
        end
        // Applied after the clear so a new producer keeps the register busy.
        if (res_en) begin
            busy_d[rf.RES_DA] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign hit_a = wr_en && (rf.DA == rf.AA);
    assign hit_b = wr_en && (rf.DA == rf.BA);

    always_comb begin
        rf.A_DATA = '0;
        rf.B_DATA = '0;
        if (rf.AA != '0) begin
            rf.A_DATA = hit_a ? rf.D_DATA : regs_q[rf.AA];
        end
        if (rf.BA != '0) begin
            rf.B_DATA = hit_b ? rf.D_DATA : regs_q[rf.BA];
        end
    end

    // A write landing this cycle resolves the hazard through the bypass.
    assign rf.A_BUSY = (rf.AA != '0) && busy_q[rf.AA] && !hit_a;
    assign rf.B_BUSY = (rf.BA != '0) && busy_q[rf.BA] && !hit_b;
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: driver pushes expected read-port values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int EW = 2 * W + 2;

    logic clk;
    logic rst;

    reg_file_if #(.WIDTH(W), .ADDR_W(AW)) rf ();

    reg_file #(.WIDTH(W), .ADDR_W(AW)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .rf    (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [EW-1:0] exp_q [$];
    string         name_q [$];
    int            tests_run    = 0;
    int            tests_failed = 0;

    // Inputs change 1 time unit after the rising edge; one cycle per call.
    task automatic drive(input logic r, input logic rw, input logic [AW-1:0] da,
                         input logic [W-1:0] d, input logic re, input logic [AW-1:0] rda,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ba);
        @(posedge clk);
        #1;
        rst       = r;
        rf.RW     = rw;
        rf.DA     = da;
        rf.D_DATA = d;
        rf.RES_EN = re;
        rf.RES_DA = rda;
        rf.AA     = aa;
        rf.BA     = ba;
    endtask

    task automatic idle_read(input logic [AW-1:0] aa, input logic [AW-1:0] ba);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, aa, ba);
    endtask

    task automatic push_exp(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ab, input logic bb);
        exp_q.push_back({a, b, ab, bb});
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            logic [EW-1:0] got;
            string         nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {rf.A_DATA, rf.B_DATA, rf.A_BUSY, rf.B_BUSY};
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL %s: got A_DATA=%h B_DATA=%h A_BUSY=%b B_BUSY=%b, expected A_DATA=%h B_DATA=%h A_BUSY=%b B_BUSY=%b",
                         nm, got[EW-1 -: W], got[W+1 -: W], got[1], got[0],
                         e[EW-1 -: W], e[W+1 -: W], e[1], e[0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        rf.RW = 1'b0; rf.DA = '0; rf.D_DATA = '0;
        rf.RES_EN = 1'b0; rf.RES_DA = '0; rf.AA = '0; rf.BA = '0;

        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        idle_read(5'd3, 5'd9);
        push_exp("reset_init", 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset wipes a stored value and a reservation.
        drive(1'b0, 1'b1, 5'd5, 32'h12345678, 1'b1, 5'd7, '0, '0);
        idle_read(5'd5, 5'd7);
        push_exp("pre_reset", 32'h12345678, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd7);
        idle_read(5'd5, 5'd7);
        push_exp("reset_mid", 32'h0, 32'h0, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 5'd1, 32'h5, 1'b0, '0, '0, '0);
        idle_read(5'd1, 5'd1);
        push_exp("wr_rd", 32'h5, 32'h5, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 5'd2, 32'h11, 1'b0, '0, '0, '0);
        idle_read(5'd2, 5'd1);
        push_exp("r2_old", 32'h11, 32'h5, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 5'd2, 32'hDEADBEEF, 1'b0, '0, 5'd2, 5'd2);
        push_exp("bypass", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
        idle_read(5'd2, 5'd2);
        push_exp("bypass_stored", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        push_exp("r0_same_cycle", 32'h0, 32'h0, 1'b0, 1'b0);
        idle_read(5'd0, 5'd0);
        push_exp("r0_after", 32'h0, 32'h0, 1'b0, 1'b0);

        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd3);
        push_exp("res_latency", 32'h0, 32'h0, 1'b0, 1'b0);
        idle_read(5'd3, 5'd1);
        push_exp("res_busy", 32'h0, 32'h5, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 5'd3, 32'hA, 1'b0, '0, 5'd3, 5'd3);
        push_exp("clear_bypass", 32'hA, 32'hA, 1'b0, 1'b0);
        idle_read(5'd3, 5'd3);
        push_exp("cleared", 32'hA, 32'hA, 1'b0, 1'b0);

        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, '0, '0);
        drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd4, 5'd3);
        push_exp("simul_cycle", 32'h44, 32'hA, 1'b0, 1'b0);
        idle_read(5'd4, 5'd4);
        push_exp("simul_set_wins", 32'h44, 32'h44, 1'b1, 1'b1);

        drive(1'b0, 1'b1, 5'd4, 32'h55, 1'b1, 5'd6, '0, '0);
        idle_read(5'd4, 5'd6);
        push_exp("set_clear_diff", 32'h55, 32'h0, 1'b0, 1'b1);

        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd6, '0, '0);
        idle_read(5'd6, 5'd6);
        push_exp("rereserve", 32'h0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, '0);
        idle_read(5'd6, 5'd4);
        push_exp("single_clear", 32'h66, 32'h55, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, '0, '0, '0);
        idle_read(5'd9, 5'd5);
        push_exp("nonbusy_write", 32'h99, 32'h0, 1'b0, 1'b0);

        // Reservation of R11 and write of R10 arrive with reset and must be dropped.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd8, '0, '0);
        drive(1'b1, 1'b1, 5'd10, 32'hABC, 1'b1, 5'd11, '0, '0);
        idle_read(5'd10, 5'd11);
        push_exp("reset_dominates", 32'h0, 32'h0, 1'b0, 1'b0);
        idle_read(5'd8, 5'd1);
        push_exp("reset_clears_all", 32'h0, 32'h0, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, '0, '0, '0);
        drive(1'b0, 1'b1, 5'd13, 32'h13, 1'b0, '0, 5'd12, 5'd13);
        push_exp("post_reset_wr_bypass_b", 32'hC0FFEE, 32'h13, 1'b0, 1'b0);
        idle_read(5'd13, 5'd12);
        push_exp("post_reset_stored", 32'h13, 32'hC0FFEE, 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/reg_file.md
# reg_file

Two-read/one-write general-purpose register file for the pipelined RISC core, and the responder to the decode/operand-fetch stage's register reads. The DOF stage presents source addresses AA/BA and receives operands A_DATA/B_DATA in the same cycle. Write-back updates the array through RW/DA/D_DATA. A per-register pending-write scoreboard lets DOF detect RAW hazards before it issues an instruction.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- ADDR_W, 5, address width; the file holds 2**ADDR_W registers, R0 included

Ports:
- CLOCK  in  1  single clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- AA  in  ADDR_W  read port A address (from DOF)
- BA  in  ADDR_W  read port B address (from DOF)
- A_DATA  out  WIDTH  read port A data, combinational
- B_DATA  out  WIDTH  read port B data, combinational
- RW  in  1  write enable from write-back
- DA  in  ADDR_W  write destination address
- D_DATA  in  WIDTH  write data
- RES_EN  in  1  reserve a destination; asserted when DOF issues an instruction that writes a register
- RES_DA  in  ADDR_W  destination address being reserved
- A_BUSY  out  1  register AA has an unresolved pending write
- B_BUSY  out  1  register BA has an unresolved pending write

## Operation
- Storage:
  - Array regs[1..2**ADDR_W-1].
  - R0 is hardwired to zero; reads of address 0 always return 0.
  - Writes to address 0 are discarded.
- Write: at a rising edge with RW=1, DA!=0 and RESET=0, regs[DA] <= D_DATA.
- Read port A, combinational:
  - If AA==0, A_DATA = 0.
  - Else if RW=1 and DA==AA, A_DATA = D_DATA (write-through bypass).
  - Else A_DATA = regs[AA].
  - Port B is identical using BA.
  - Both ports may address the same register; both return the same value.
- Scoreboard: busy bit per register; busy[0] is constant 0.
  - Set: at an edge with RES_EN=1 and RES_DA!=0, busy[RES_DA] <= 1.
  - Clear: at an edge with RW=1 and DA!=0, busy[DA] <= 0.
  - Same register set and cleared in the same edge: set wins. The write data is still stored, and the newer producer keeps the register busy.
  - Set and clear on different registers in the same edge: both take effect.
  - Reserving an already-busy register leaves it busy. There is no counting.
  - Write-back to a non-busy register is legal and simply writes the data.
- Busy outputs:
  - A_BUSY = busy[AA] AND NOT (RW=1 and DA==AA). A write landing in the current cycle resolves the hazard through the bypass.
  - Address 0 is never busy.
  - B_BUSY is identical using BA.
- Reset:
  - At an edge with RESET=1, every regs[i] <= 0 and every busy[i] <= 0.
  - RW and RES_EN are ignored on that edge; reset dominates.
  - Outputs are combinational from state and inputs. After the reset edge, A_DATA/B_DATA read 0 and A_BUSY/B_BUSY read 0, unless a bypassing write is presented in the same cycle.

## Timing
- Read latency 0 cycles: A_DATA/B_DATA follow AA/BA/RW/DA/D_DATA combinationally.
- Write latency:
  - Visible on the read ports in the same cycle via the bypass.
  - Stored in the array at the next rising edge.
- Reservation latency: busy becomes visible on A_BUSY/B_BUSY in the cycle after the RES_EN edge.
- Clear latency:
  - A_BUSY drops in the same cycle RW/DA targets AA (bypass term).
  - The busy bit itself clears at the edge.
- No handshake or backpressure: every write and reservation presented at an edge is accepted, except while RESET=1.
- Reset mid-operation: pending reservations and all register contents are lost at the reset edge. In-flight write-backs arriving after reset still write normally.

## Test plan
- Reset: drive RESET=1 for one edge after writing R5=0x12345678 and reserving R7. Then AA=5, BA=7 -> A_DATA=0, B_DATA=0, A_BUSY=0, B_BUSY=0.
- Write/read: RW=1, DA=1, D_DATA=0x00000005 for one edge, then RW=0, AA=1, BA=1 -> A_DATA=B_DATA=0x00000005.
- Bypass: with R2 holding 0x00000011, present RW=1, DA=2, D_DATA=0xDEADBEEF with AA=2 before the edge -> A_DATA=0xDEADBEEF in that cycle. After the edge with RW=0 -> still 0xDEADBEEF.
- R0: RW=1, DA=0, D_DATA=0xFFFFFFFF, RES_EN=1, RES_DA=0 for one edge. Then AA=0 -> A_DATA=0, A_BUSY=0.
- Scoreboard sequence:
  - RES_EN=1, RES_DA=3 at edge N; AA=3 in cycle N+1 -> A_BUSY=1.
  - In cycle N+2, RW=1, DA=3, D_DATA=0x0000000A -> A_BUSY=0 and A_DATA=0x0000000A combinationally.
  - After the edge -> busy[3]=0.
- Simultaneous set/clear: R4 busy; at one edge RW=1, DA=4, D_DATA=0x00000044 and RES_EN=1, RES_DA=4. Next cycle with AA=4, RW=0 -> A_DATA=0x00000044 and A_BUSY=1.
